// File: rtl/modmul_sched_pkg.sv
// Shared definitions for the modmul scheduler: FSM encoding and the modmul build latency.
// LATENCY follows the modmul build (USE_DFF_MODMUL adds register stages), so define it once here.
`ifndef MODMUL_LATENCY
`define MODMUL_LATENCY 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 64
`endif

package modmul_sched_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } sched_state_t;

    localparam int MM_LATENCY   = `MODMUL_LATENCY;
    localparam int MM_WORD_SIZE = `WORD_SIZE;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/modmul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping around.
// The pointer moves one past the winner only when the grant is actually taken.
module modmul_sched_rr_arbiter
    import modmul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] win;
    logic            found;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (enable && found) begin
            grant[win] = 1'b1;
        end
    end

    assign grant_id = win;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ID_W'(wrap_inc(32'(win), NUM_REQ));
        end
    end

endmodule

// File: rtl/modmul_sched.sv
// Shares one fixed-latency pipelined modmul between NUM_REQ requesters, tags each result
// with its requester id, and sequences modulus changes (drain, load q, settle, resume).
module modmul_sched
    import modmul_sched_pkg::*;
#(
    parameter int                    NUM_REQ   = 4,
    parameter int                    WORD_SIZE = MM_WORD_SIZE,
    parameter int                    LATENCY   = MM_LATENCY,
    parameter int                    Q_SETTLE  = 2,
    parameter int                    ID_W      = $clog2(NUM_REQ),
    parameter logic [WORD_SIZE-1:0]  Q_INIT    = '0,
    localparam int                   CNT_W     = $clog2(LATENCY + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_a,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_b,
    input  logic                           cfg_valid,
    input  logic [WORD_SIZE-1:0]           cfg_q,
    output logic                           cfg_ready,
    output logic [WORD_SIZE-1:0]           mm_a,
    output logic [WORD_SIZE-1:0]           mm_b,
    output logic [WORD_SIZE-1:0]           mm_q,
    input  logic [WORD_SIZE-1:0]           mm_c,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [WORD_SIZE-1:0]           rsp_c,
    output logic [CNT_W-1:0]               inflight
);

    localparam int SET_W = (Q_SETTLE > 1) ? $clog2(Q_SETTLE) : 1;
    localparam int SETTLE_LOAD = (Q_SETTLE > 0) ? Q_SETTLE - 1 : 0;

    sched_state_t          state;
    sched_state_t          state_nxt;
    logic [SET_W-1:0]      settle_cnt;
    logic [WORD_SIZE-1:0]  pending_q;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  arb_en;
    logic                  issue;
    logic                  cfg_take;
    logic                  q_load;
    logic [CNT_W-1:0]      inflight_nxt;

    // Tag stage k holds the operation that entered modmul k cycles ago.
    logic                  tag_vld_p [0:LATENCY];
    logic [ID_W-1:0]       tag_id_p  [0:LATENCY];

    modmul_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .enable   (arb_en),
        .advance  (issue),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign issue     = |(req_valid & grant);

    always_comb begin
        inflight_nxt = inflight;
        if (issue && !rsp_valid) begin
            inflight_nxt = inflight + CNT_W'(1);
        end else if (!issue && rsp_valid) begin
            inflight_nxt = inflight - CNT_W'(1);
        end
    end

    // The new q is loaded on the edge that retires the last result, so nothing in flight sees it.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        arb_en    = 1'b0;
        cfg_take  = 1'b0;
        q_load    = 1'b0;
        case (state)
            RUN: begin
                cfg_ready = 1'b1;
                arb_en    = !cfg_valid;
                if (cfg_valid) begin
                    cfg_take  = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_nxt == '0) begin
                    q_load    = 1'b1;
                    state_nxt = (Q_SETTLE == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            settle_cnt <= '0;
            inflight   <= '0;
            mm_q       <= Q_INIT;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            if (q_load) begin
                mm_q       <= pending_q;
                settle_cnt <= SET_W'(SETTLE_LOAD);
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_take) begin
            pending_q <= cfg_q;
        end
    end

    // Operand register: the modmul input stage, held when nothing issues.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mm_a <= '0;
            mm_b <= '0;
        end else if (issue) begin
            mm_a <= req_a[32'(grant_id)*WORD_SIZE +: WORD_SIZE];
            mm_b <= req_b[32'(grant_id)*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= LATENCY; k++) begin
                tag_vld_p[k] <= 1'b0;
                tag_id_p[k]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= issue;
            tag_id_p[0]  <= grant_id;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_vld_p[k] <= tag_vld_p[k-1];
                tag_id_p[k]  <= tag_id_p[k-1];
            end
        end
    end

    // Result stage: last tag lines up with mm_c.
    assign rsp_valid = tag_vld_p[LATENCY];
    assign rsp_id    = tag_id_p[LATENCY];
    assign rsp_c     = mm_c;

endmodule

// File: tb/tb_modmul_sched.sv
// Directed bench for modmul_sched with a Montgomery modmul model and a response scoreboard.
module tb_modmul_sched;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int L   = 8;
    localparam int QS  = 2;
    localparam int IDW = 2;
    localparam int CW  = 4;
    localparam logic [63:0] QP = 64'hFFFFFFFF00000001;
    localparam logic [63:0] Q2 = 64'hFFFFFFFFFFFFFFC5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           cfg_valid;
    logic [W-1:0]   cfg_q;
    logic           cfg_ready;
    logic [W-1:0]   mm_a;
    logic [W-1:0]   mm_b;
    logic [W-1:0]   mm_q;
    logic [W-1:0]   mm_c;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_c;
    logic [CW-1:0]  inflight;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int nrsp;
    logic [63:0] cur_q;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] c;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
        logic [3:0] infl;
    } vec_t;
    vec_t tv [21];

    logic [3:0] g4 [5];
    logic [63:0] mpipe [L];

    modmul_sched #(
        .NUM_REQ   (N),
        .WORD_SIZE (W),
        .LATENCY   (L),
        .Q_SETTLE  (QS),
        .ID_W      (IDW),
        .Q_INIT    (64'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .cfg_valid (cfg_valid),
        .cfg_q     (cfg_q),
        .cfg_ready (cfg_ready),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_q      (mm_q),
        .mm_c      (mm_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a*b*2^-64 mod q by shifting out 64 factors of two
    function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
        logic [128:0] x;
        if (q == 64'h0) return 64'h0;
        x = ({65'd0, a} * {65'd0, b}) % {65'd0, q};
        for (int i = 0; i < 64; i++) begin
            if (x[0]) x = x + {65'd0, q};
            x = x >> 1;
        end
        return x[63:0];
    endfunction

    always @(posedge clk) begin
        mpipe[0] <= mont(mm_a, mm_b, mm_q);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mm_c = mpipe[L-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int row);
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 64'((row + 1) * 16 + i);
            req_b[i*W +: W] = 64'(row * 3 + i + 7);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected none (cycle %0d)", rsp_id, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                    chk("rsp_c", rsp_c, mon_e.c);
                    chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{2'(i), mont(req_a[i*W +: W], req_b[i*W +: W], cur_q), cyc + 1 + L});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tv[0] = '{4'b1000, 4'b1000, 4'd0};
        for (int r = 1; r <= 12; r++) begin
            tv[r].vld  = 4'b1111;
            tv[r].rdy  = 4'b0001 << ((r - 1) % 4);
            tv[r].infl = (r <= 9) ? 4'(r) : 4'd9;
        end
        tv[13] = '{4'b1010, 4'b0010, 4'd9};
        tv[14] = '{4'b1010, 4'b1000, 4'd9};
        tv[15] = '{4'b1010, 4'b0010, 4'd9};
        tv[16] = '{4'b1010, 4'b1000, 4'd9};
        tv[17] = '{4'b0000, 4'b0000, 4'd9};
        tv[18] = '{4'b0101, 4'b0001, 4'd8};
        tv[19] = '{4'b0101, 4'b0100, 4'd8};
        tv[20] = '{4'b0001, 4'b0001, 4'd8};
        g4[0] = 4'b0010; g4[1] = 4'b0100; g4[2] = 4'b1000; g4[3] = 4'b0001; g4[4] = 4'b0010;

        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        cfg_valid = 1'b0; cfg_q = '0; cur_q = 64'h0;
        repeat (2) step();
        #2;
        chk("rst_inflight", 64'(inflight), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_id", 64'(rsp_id), 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        chk("rst_mm_q", mm_q, 0);
        chk("rst_cfg_ready", 64'(cfg_ready), 1);
        step();
        rst = 1'b1;

        // cfg and req[2] together on an empty pipeline
        step();
        cfg_valid = 1'b1; cfg_q = QP; cur_q = QP; req_valid = 4'b0100; set_ops(40);
        #2;
        chk("t6_ready_cfg_cycle", 64'(req_ready), 0);
        chk("t6_cfg_ready_run", 64'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        #2;
        chk("t6_ready_drain", 64'(req_ready), 0);
        chk("t6_cfg_ready_drain", 64'(cfg_ready), 0);
        chk("t6_mm_q_drain", mm_q, 0);
        step(); #2;
        chk("t6_mm_q_settle", mm_q, QP);
        chk("t6_ready_settle0", 64'(req_ready), 0);
        step(); #2;
        chk("t6_ready_settle1", 64'(req_ready), 0);
        chk("t6_cfg_ready_settle1", 64'(cfg_ready), 0);
        step(); #2;
        chk("t6_grant_req2", 64'(req_ready), 64'b0100);
        chk("t6_cfg_ready_run_again", 64'(cfg_ready), 1);
        step();
        req_valid = '0;
        repeat (10) step();

        // single request from requester 0
        req_valid = 4'b0001; req_a = '0; req_b = '0;
        req_a[W-1:0] = 64'd3; req_b[W-1:0] = 64'd5;
        #2;
        chk("t1_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        #2;
        chk("t1_inflight_1", 64'(inflight), 1);
        chk("t1_rsp_k1", 64'(rsp_valid), 0);
        for (int k = 2; k <= 10; k++) begin
            step(); #2;
            chk("t1_rsp_valid", 64'(rsp_valid), 64'(k == 9));
            if (k == 9) begin
                chk("t1_rsp_id", 64'(rsp_id), 0);
                chk("t1_rsp_c", rsp_c, 64'hFFFFFFF000000001);
                chk("t1_inflight_at_rsp", 64'(inflight), 1);
            end
            if (k == 10) chk("t1_inflight_0", 64'(inflight), 0);
        end

        // 5 operations in flight, then a modulus change
        step();
        req_valid = 4'b1111; set_ops(50);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            #2;
            chk("t4_grant", 64'(req_ready), 64'(g4[k]));
        end
        step();
        cfg_valid = 1'b1; cfg_q = Q2; cur_q = Q2;
        #2;
        chk("t4_ready_cfg_cycle", 64'(req_ready), 0);
        chk("t4_cfg_ready_cfg_cycle", 64'(cfg_ready), 1);
        chk("t4_inflight_5", 64'(inflight), 5);
        nrsp = 0;
        for (int k = 6; k <= 16; k++) begin
            step();
            cfg_valid = 1'b0;
            #2;
            chk("t4_cfg_ready", 64'(cfg_ready), 64'(k == 16));
            chk("t4_ready", 64'(req_ready), (k == 16) ? 64'b0100 : 64'h0);
            chk("t4_mm_q", mm_q, (k >= 14) ? Q2 : QP);
            if (k == 13) chk("t4_inflight_last", 64'(inflight), 1);
            if (k == 14) chk("t4_inflight_empty", 64'(inflight), 0);
            nrsp += int'(rsp_valid);
        end
        chk("t4_rsp_count", 64'(nrsp), 5);
        step();
        req_valid = '0;
        repeat (10) step();

        // reset with 6 operations outstanding
        req_valid = 4'b1111; set_ops(60);
        repeat (5) step();
        step();
        req_valid = '0;
        #2;
        chk("t5_inflight_pre", 64'(inflight), 6);
        step();
        rst = 1'b0; sb.delete(); cur_q = 64'h0;
        step();
        rst = 1'b1;
        #2;
        chk("t5_inflight_post", 64'(inflight), 0);
        chk("t5_mm_q_post", mm_q, 0);
        nrsp = 0;
        for (int k = 0; k < 20; k++) begin
            step(); #2;
            nrsp += int'(rsp_valid);
        end
        chk("t5_no_rsp", 64'(nrsp), 0);
        chk("t5_inflight_idle", 64'(inflight), 0);
        step();
        req_valid = 4'b1111; set_ops(70);
        #2;
        chk("t5_first_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;

        // back to q=QP, then the arbitration table
        step();
        cfg_valid = 1'b1; cfg_q = QP; cur_q = QP;
        step();
        cfg_valid = 1'b0;
        repeat (14) step();
        #2;
        chk("tbl_pre_mm_q", mm_q, QP);
        for (int r = 0; r < 21; r++) begin
            step();
            req_valid = tv[r].vld; set_ops(r);
            #2;
            chk("tbl_ready", 64'(req_ready), 64'(tv[r].rdy));
            chk("tbl_inflight", 64'(inflight), 64'(tv[r].infl));
        end
        step();
        req_valid = '0;
        repeat (12) step();
        #2;
        chk("end_inflight", 64'(inflight), 0);
        chk("end_scoreboard_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
